// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the two-master Wishbone B4 classic arbiter.
//   - WB_AW / WB_DW : widest address / data the master bundle can carry;
//                     the arbiter's AW and DW parameters must not exceed them.
//   - ARB_*         : arbiter FSM state encodings.
//   - wb_master_t   : one master's request bundle (cyc, stb, we, sel, adr, dat).
// -----------------------------------------------------------------------------
package wb_arb_pkg;

   localparam int WB_AW = 30;
   localparam int WB_DW = 32;

   localparam logic [1:0] ARB_IDLE = 2'd0;
   localparam logic [1:0] ARB_OWN0 = 2'd1;
   localparam logic [1:0] ARB_OWN1 = 2'd2;

   typedef struct packed {
      logic             cyc;
      logic             stb;
      logic             we;
      logic [3:0]       sel;
      logic [WB_AW-1:0] adr;
      logic [WB_DW-1:0] dat;
   } wb_master_t;

endpackage

// File: rtl/wb_watchdog.sv
// -----------------------------------------------------------------------------
// wb_watchdog
// Counts consecutive cycles in which the bus owner strobes without any slave
// response and pulses o_fire on the TIMEOUT-th such cycle.
//   i_clk   : system clock
//   i_rst   : synchronous, active-high reset
//   i_clear : forces the count to zero (bus idle)
//   i_stb   : owner's strobe
//   i_ack   : slave acknowledge
//   i_err   : slave error
//   o_fire  : one-cycle pulse, combinational in the cycle the limit is hit
// -----------------------------------------------------------------------------
module wb_watchdog #(
   parameter int TIMEOUT = 255,
   parameter int TO_BITS = 8
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_stb,
   input  logic i_ack,
   input  logic i_err,
   output logic o_fire
);

   // r_count holds the number of stalled cycles already completed, so the
   // current cycle is the TIMEOUT-th stalled one when r_count == TIMEOUT-1.
   localparam logic [TO_BITS-1:0] LAST_STALL = TO_BITS'(TIMEOUT - 1);

   logic [TO_BITS-1:0] r_count;
   logic               w_stall;

   // A real response in the same cycle is not a stall, so it also blocks firing.
   assign w_stall = i_stb & ~i_ack & ~i_err & ~i_clear;
   assign o_fire  = w_stall & (r_count == LAST_STALL);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of block ordering.
   always_ff @(posedge i_clk) begin
      if (i_rst || !w_stall || o_fire) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + TO_BITS'(1);
      end
   end

endmodule

// File: rtl/wb_arbiter2.sv
// -----------------------------------------------------------------------------
// wb_arbiter2
// Two-master Wishbone B4 classic arbiter with round-robin grant per bus cycle
// and a watchdog that terminates strobes no slave answers.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   m0_* / m1_*             : master ports (cyc, stb, we, sel, adr, dat in;
//                             dat, ack, err out)
//   s_cyc_o .. s_dat_o      : shared bus request, copy of the owner
//   s_dat_i, s_ack_i, s_err_i : shared bus response, routed to the owner only
//   gnt_o                   : one-hot owner, 00 when idle
//   timeout_o               : one-cycle pulse when the watchdog fires
// AW and DW must not exceed WB_AW / WB_DW from wb_arb_pkg.
// -----------------------------------------------------------------------------
module wb_arbiter2
   import wb_arb_pkg::*;
#(
   parameter int AW      = 30,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255,
   parameter int TO_BITS = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   // master 0 (CPU)
   input  logic          m0_cyc_i,
   input  logic          m0_stb_i,
   input  logic          m0_we_i,
   input  logic [3:0]    m0_sel_i,
   input  logic [AW-1:0] m0_adr_i,
   input  logic [DW-1:0] m0_dat_i,
   output logic [DW-1:0] m0_dat_o,
   output logic          m0_ack_o,
   output logic          m0_err_o,
   // master 1 (DMA / fetch engine)
   input  logic          m1_cyc_i,
   input  logic          m1_stb_i,
   input  logic          m1_we_i,
   input  logic [3:0]    m1_sel_i,
   input  logic [AW-1:0] m1_adr_i,
   input  logic [DW-1:0] m1_dat_i,
   output logic [DW-1:0] m1_dat_o,
   output logic          m1_ack_o,
   output logic          m1_err_o,
   // shared bus
   output logic          s_cyc_o,
   output logic          s_stb_o,
   output logic          s_we_o,
   output logic [3:0]    s_sel_o,
   output logic [AW-1:0] s_adr_o,
   output logic [DW-1:0] s_dat_o,
   input  logic [DW-1:0] s_dat_i,
   input  logic          s_ack_i,
   input  logic          s_err_i,
   // status
   output logic [1:0]    gnt_o,
   output logic          timeout_o
);

   logic [1:0]  r_state;
   logic        r_last;      // master that won the most recent grant
   logic [1:0]  w_state_nxt;
   logic        w_last_nxt;
   logic        w_own0;
   logic        w_own1;
   logic        w_fire;
   wb_master_t  w_m0;
   wb_master_t  w_m1;
   wb_master_t  w_own;

   assign w_m0 = '{cyc: m0_cyc_i, stb: m0_stb_i, we: m0_we_i, sel: m0_sel_i,
                   adr: WB_AW'(m0_adr_i), dat: WB_DW'(m0_dat_i)};
   assign w_m1 = '{cyc: m1_cyc_i, stb: m1_stb_i, we: m1_we_i, sel: m1_sel_i,
                   adr: WB_AW'(m1_adr_i), dat: WB_DW'(m1_dat_i)};

   assign w_own0 = (r_state == ARB_OWN0);
   assign w_own1 = (r_state == ARB_OWN1);

   // NOTE: every signal driven in always_comb gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      w_own = '0;
      if (w_own0) begin
         w_own = w_m0;
      end else if (w_own1) begin
         w_own = w_m1;
      end
   end

   wb_watchdog #(
      .TIMEOUT (TIMEOUT),
      .TO_BITS (TO_BITS)
   ) u_watchdog (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_clear (r_state == ARB_IDLE),
      .i_stb   (w_own.stb),
      .i_ack   (s_ack_i),
      .i_err   (s_err_i),
      .o_fire  (w_fire)
   );

   // Shared bus: copy of the owner; a watchdog hit drops cyc/stb that cycle.
   assign s_cyc_o = w_own.cyc & ~w_fire;
   assign s_stb_o = w_own.stb & ~w_fire;
   assign s_we_o  = w_own.we;
   assign s_sel_o = w_own.sel;
   assign s_adr_o = AW'(w_own.adr);
   assign s_dat_o = DW'(w_own.dat);

   // Response return: owner only; the watchdog terminates with err.
   assign m0_ack_o = w_own0 & s_ack_i;
   assign m0_err_o = w_own0 & (s_err_i | w_fire);
   assign m0_dat_o = w_own0 ? s_dat_i : '0;
   assign m1_ack_o = w_own1 & s_ack_i;
   assign m1_err_o = w_own1 & (s_err_i | w_fire);
   assign m1_dat_o = w_own1 ? s_dat_i : '0;

   assign gnt_o     = {w_own1, w_own0};
   assign timeout_o = w_fire;

   // Grants come only from IDLE, so every tenure is followed by one idle
   // cycle. r_last tracks every winner, contended or not, which keeps the
   // alternation fair.
   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      case (r_state)
         ARB_IDLE: begin
            if (m0_cyc_i && (!m1_cyc_i || r_last)) begin
               w_state_nxt = ARB_OWN0;
               w_last_nxt  = 1'b0;
            end else if (m1_cyc_i) begin
               w_state_nxt = ARB_OWN1;
               w_last_nxt  = 1'b1;
            end
         end
         ARB_OWN0: begin
            if (!m0_cyc_i || w_fire) w_state_nxt = ARB_IDLE;
         end
         ARB_OWN1: begin
            if (!m1_cyc_i || w_fire) w_state_nxt = ARB_IDLE;
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   // r_last resets to 1 so master 0 wins the first contention.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ARB_IDLE;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_last  <= w_last_nxt;
      end
   end

endmodule

// File: tb/tb_wb_arbiter2.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter2
// Self-checking bench for wb_arbiter2 (TIMEOUT = 8). A behavioural model
// (owner as an integer, stall count, last winner) predicts every output each
// cycle; a table of vectors and hand-written sequences check the corner cases,
// then randomized traffic runs against the model.
// -----------------------------------------------------------------------------
module tb_wb_arbiter2;

   localparam int AW      = 30;
   localparam int DW      = 32;
   localparam int TIMEOUT = 8;
   localparam int TO_BITS = 8;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          m0_cyc_i, m0_stb_i, m0_we_i;
   logic [3:0]    m0_sel_i;
   logic [AW-1:0] m0_adr_i;
   logic [DW-1:0] m0_dat_i, m0_dat_o;
   logic          m0_ack_o, m0_err_o;
   logic          m1_cyc_i, m1_stb_i, m1_we_i;
   logic [3:0]    m1_sel_i;
   logic [AW-1:0] m1_adr_i;
   logic [DW-1:0] m1_dat_i, m1_dat_o;
   logic          m1_ack_o, m1_err_o;
   logic          s_cyc_o, s_stb_o, s_we_o;
   logic [3:0]    s_sel_o;
   logic [AW-1:0] s_adr_o;
   logic [DW-1:0] s_dat_o, s_dat_i;
   logic          s_ack_i, s_err_i;
   logic [1:0]    gnt_o;
   logic          timeout_o;

   always #5 clk_i = ~clk_i;

   wb_arbiter2 #(
      .AW (AW), .DW (DW), .TIMEOUT (TIMEOUT), .TO_BITS (TO_BITS)
   ) dut (
      .clk_i (clk_i), .rst_i (rst_i),
      .m0_cyc_i (m0_cyc_i), .m0_stb_i (m0_stb_i), .m0_we_i (m0_we_i),
      .m0_sel_i (m0_sel_i), .m0_adr_i (m0_adr_i), .m0_dat_i (m0_dat_i),
      .m0_dat_o (m0_dat_o), .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o),
      .m1_cyc_i (m1_cyc_i), .m1_stb_i (m1_stb_i), .m1_we_i (m1_we_i),
      .m1_sel_i (m1_sel_i), .m1_adr_i (m1_adr_i), .m1_dat_i (m1_dat_i),
      .m1_dat_o (m1_dat_o), .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o),
      .s_cyc_o (s_cyc_o), .s_stb_o (s_stb_o), .s_we_o (s_we_o),
      .s_sel_o (s_sel_o), .s_adr_o (s_adr_o), .s_dat_o (s_dat_o),
      .s_dat_i (s_dat_i), .s_ack_i (s_ack_i), .s_err_i (s_err_i),
      .gnt_o (gnt_o), .timeout_o (timeout_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic check_vec(input string name, input logic [159:0] got, input logic [159:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   int mdl_owner = -1;   // -1 idle, else master index
   int mdl_last  = 1;    // index of the most recent winner
   int mdl_stall = 0;    // stalled strobe cycles completed in this tenure
   bit mdl_valid = 1'b0; // model is meaningful once a reset has been applied

   function automatic logic [159:0] pack_actual();
      return {20'b0, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
              m0_dat_o, m0_ack_o, m0_err_o, m1_dat_o, m1_ack_o, m1_err_o,
              gnt_o, timeout_o};
   endfunction

   function automatic bit mdl_fire();
      logic stb;
      if (mdl_owner < 0) return 1'b0;
      stb = (mdl_owner == 0) ? m0_stb_i : m1_stb_i;
      // this cycle is the TIMEOUT-th consecutive unanswered strobe
      return stb && !s_ack_i && !s_err_i && (mdl_stall + 1 == TIMEOUT);
   endfunction

   function automatic logic [159:0] mdl_expect();
      bit            f;
      logic          cyc, stb, we, a0, e0, a1, e1;
      logic [3:0]    sel;
      logic [AW-1:0] adr;
      logic [DW-1:0] dat, d0, d1;
      logic [1:0]    g;
      f = mdl_fire();
      {cyc, stb, we, a0, e0, a1, e1} = '0;
      sel = '0; adr = '0; dat = '0; d0 = '0; d1 = '0; g = 2'b00;
      if (mdl_owner == 0) begin
         cyc = m0_cyc_i; stb = m0_stb_i; we = m0_we_i; sel = m0_sel_i;
         adr = m0_adr_i; dat = m0_dat_i;
         d0 = s_dat_i; a0 = s_ack_i; e0 = s_err_i | f; g = 2'b01;
      end else if (mdl_owner == 1) begin
         cyc = m1_cyc_i; stb = m1_stb_i; we = m1_we_i; sel = m1_sel_i;
         adr = m1_adr_i; dat = m1_dat_i;
         d1 = s_dat_i; a1 = s_ack_i; e1 = s_err_i | f; g = 2'b10;
      end
      return {20'b0, cyc & ~f, stb & ~f, we, sel, adr, dat,
              d0, a0, e0, d1, a1, e1, g, f};
   endfunction

   task automatic mdl_update();
      bit   f;
      logic own_cyc, own_stb;
      f = mdl_fire();
      if (rst_i) begin
         mdl_owner = -1; mdl_last = 1; mdl_stall = 0; mdl_valid = 1'b1;
      end else if (!mdl_valid) begin
         mdl_owner = -1;
      end else if (mdl_owner < 0) begin
         mdl_stall = 0;
         if (m0_cyc_i && m1_cyc_i) mdl_owner = 1 - mdl_last;
         else if (m0_cyc_i)        mdl_owner = 0;
         else if (m1_cyc_i)        mdl_owner = 1;
         if (mdl_owner >= 0) mdl_last = mdl_owner;
      end else begin
         own_cyc = (mdl_owner == 0) ? m0_cyc_i : m1_cyc_i;
         own_stb = (mdl_owner == 0) ? m0_stb_i : m1_stb_i;
         if (f || !own_cyc) begin
            mdl_owner = -1; mdl_stall = 0;
         end else if (own_stb && !s_ack_i && !s_err_i) begin
            mdl_stall++;
         end else begin
            mdl_stall = 0;
         end
      end
   endtask

   // Inputs are driven at the falling edge; outputs are compared 1 time unit
   // later, well away from the rising edge.
   task automatic apply();
      #1;
      if (mdl_valid) check_vec("model", pack_actual(), mdl_expect());
   endtask

   task automatic advance();
      @(posedge clk_i);
      mdl_update();
      @(negedge clk_i);
   endtask

   task automatic set_masters(input logic c0, input logic s0, input logic c1, input logic s1);
      m0_cyc_i = c0; m0_stb_i = s0; m1_cyc_i = c1; m1_stb_i = s1;
   endtask

   typedef struct {
      logic       rst, c0, s0, c1, s1, ack;
      logic [1:0] gnt;
      logic       scyc, a0, a1;
   } vec_t;

   vec_t tbl[12];
   int   ack_pct[6];

   initial begin
      #1_000_000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "bench did not finish");
   end

   initial begin
      // fixed stimulus for the directed part
      rst_i = 1'b1;
      set_masters(0, 0, 0, 0);
      m0_we_i = 1'b0; m0_sel_i = 4'hF; m0_adr_i = 30'h30_0010; m0_dat_i = 32'h1111_0000;
      m1_we_i = 1'b1; m1_sel_i = 4'h3; m1_adr_i = 30'h10_0040; m1_dat_i = 32'h2222_0000;
      s_dat_i = 32'hDEAD_BEEF; s_ack_i = 1'b0; s_err_i = 1'b0;

      // reset state
      advance();
      apply();
      check_vec("reset_outputs", pack_actual(), 160'b0);
      advance();

      // contention / release / alternation table (expected values hand-derived)
      //            rst c0 s0 c1 s1 ack  gnt   scyc a0 a1
      tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,1'b0};
      tbl[1]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 2'b00,1'b0,1'b0,1'b0};
      tbl[2]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b1, 2'b01,1'b1,1'b1,1'b0};
      tbl[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 2'b01,1'b0,1'b0,1'b0};
      tbl[4]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 2'b00,1'b0,1'b0,1'b0};
      tbl[5]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b1, 2'b10,1'b1,1'b0,1'b1};
      tbl[6]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 2'b10,1'b1,1'b0,1'b0};
      tbl[7]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b10,1'b0,1'b0,1'b0};
      tbl[8]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 2'b00,1'b0,1'b0,1'b0};
      tbl[9]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b1, 2'b01,1'b1,1'b1,1'b0};
      tbl[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,1'b0,1'b0,1'b0};
      tbl[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,1'b0};
      for (int i = 0; i < 12; i++) begin
         rst_i = tbl[i].rst;
         set_masters(tbl[i].c0, tbl[i].s0, tbl[i].c1, tbl[i].s1);
         s_ack_i = tbl[i].ack;
         apply();
         check($sformatf("vec%0d_gnt", i), 32'(gnt_o), 32'(tbl[i].gnt));
         check($sformatf("vec%0d_scyc", i), 32'(s_cyc_o), 32'(tbl[i].scyc));
         check($sformatf("vec%0d_acks", i), 32'({m0_ack_o, m1_ack_o}), 32'({tbl[i].a0, tbl[i].a1}));
         advance();
      end
      rst_i = 1'b0; s_ack_i = 1'b0;

      // A: m0-only read, slave acks 2 cycles after the strobe reaches the bus
      set_masters(1, 1, 0, 0);
      apply(); check("A_idle_gnt", 32'(gnt_o), 32'(2'b00)); advance();
      apply(); check("A_gnt", 32'(gnt_o), 32'(2'b01));
      check("A_stb", 32'(s_stb_o), 32'd1);
      check("A_adr", 32'(s_adr_o), 32'h0030_0010); advance();
      apply(); advance();
      s_ack_i = 1'b1;
      apply(); check("A_m0_ack", 32'(m0_ack_o), 32'd1);
      check("A_m0_dat", m0_dat_o, 32'hDEAD_BEEF);
      check("A_m1_ack", 32'(m1_ack_o), 32'd0);
      check("A_m1_dat", m1_dat_o, 32'd0); advance();
      s_ack_i = 1'b0; set_masters(0, 0, 0, 0);
      apply(); advance();
      apply(); check("A_release_gnt", 32'(gnt_o), 32'(2'b00)); advance();

      // E: m1 4-strobe burst while m0 waits
      set_masters(0, 0, 1, 1);
      apply(); advance();
      set_masters(1, 1, 1, 1);
      for (int k = 0; k < 4; k++) begin
         s_ack_i = 1'b0;
         apply(); check($sformatf("E_wait%0d_gnt", k), 32'(gnt_o), 32'(2'b10)); advance();
         s_ack_i = 1'b1;
         apply(); check($sformatf("E_ack%0d", k), 32'({m1_ack_o, m0_ack_o}), 32'(2'b10)); advance();
      end
      s_ack_i = 1'b0; set_masters(1, 1, 0, 0);
      apply(); check("E_drop_gnt", 32'(gnt_o), 32'(2'b10)); advance();
      apply(); check("E_gap_gnt", 32'(gnt_o), 32'(2'b00)); advance();
      apply(); check("E_m0_gnt", 32'(gnt_o), 32'(2'b01)); advance();
      set_masters(0, 0, 0, 0);
      apply(); advance();
      apply(); advance();

      // B: watchdog fires on the 8th stalled cycle
      set_masters(1, 1, 0, 0);
      apply(); advance();
      for (int k = 1; k < TIMEOUT; k++) begin
         apply(); check($sformatf("B_stall%0d", k), 32'({timeout_o, m0_err_o, s_cyc_o}), 32'(3'b001)); advance();
      end
      apply();
      check("B_fire", 32'({timeout_o, m0_err_o, s_cyc_o, s_stb_o}), 32'(4'b1100));
      check("B_gnt_at_fire", 32'(gnt_o), 32'(2'b01)); advance();
      set_masters(0, 0, 0, 0);
      apply(); check("B_idle_after", 32'({gnt_o, timeout_o}), 32'(3'b000)); advance();

      // C: ack on the very cycle the limit is reached wins
      set_masters(1, 1, 0, 0);
      apply(); advance();
      for (int k = 1; k < TIMEOUT; k++) begin
         apply(); advance();
      end
      s_ack_i = 1'b1;
      apply();
      check("C_ack_wins", 32'({m0_ack_o, m0_err_o, timeout_o, s_cyc_o}), 32'(4'b1001)); advance();
      s_ack_i = 1'b0; set_masters(0, 0, 0, 0);
      apply(); check("C_still_owned", 32'(gnt_o), 32'(2'b01)); advance();
      apply(); advance();

      // D: reset mid-burst while m1 owns the bus
      set_masters(0, 0, 1, 1);
      apply(); advance();
      s_ack_i = 1'b1;
      apply(); advance();
      apply(); advance();
      s_ack_i = 1'b0; rst_i = 1'b1;
      apply(); check("D_owner_before_rst", 32'(gnt_o), 32'(2'b10)); advance();
      rst_i = 1'b0; set_masters(1, 1, 1, 1);
      apply(); check_vec("D_reset_outputs", pack_actual(), 160'b0); advance();
      apply(); check("D_m0_first", 32'(gnt_o), 32'(2'b01)); advance();
      set_masters(0, 0, 0, 0);
      apply(); advance();
      apply(); advance();

      // randomized traffic against the model
      ack_pct[0] = 0;  ack_pct[1] = 15; ack_pct[2] = 40;
      ack_pct[3] = 5;  ack_pct[4] = 60; ack_pct[5] = 25;
      for (int seg = 0; seg < 6; seg++) begin
         for (int n = 0; n < 500; n++) begin
            if ($urandom_range(99) < 10) m0_cyc_i = ~m0_cyc_i;
            if ($urandom_range(99) < 10) m1_cyc_i = ~m1_cyc_i;
            m0_stb_i = m0_cyc_i & (($urandom_range(99) < 15) ? ~m0_stb_i : m0_stb_i);
            m1_stb_i = m1_cyc_i & (($urandom_range(99) < 15) ? ~m1_stb_i : m1_stb_i);
            m0_we_i  = 1'($urandom); m1_we_i = 1'($urandom);
            m0_sel_i = 4'($urandom); m1_sel_i = 4'($urandom);
            m0_adr_i = AW'($urandom); m1_adr_i = AW'($urandom);
            m0_dat_i = $urandom; m1_dat_i = $urandom;
            s_dat_i  = $urandom;
            s_ack_i  = ($urandom_range(99) < ack_pct[seg]);
            s_err_i  = ($urandom_range(99) < 3);
            rst_i    = ($urandom_range(999) < 5);
            apply();
            advance();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
